// File: rtl/thor_dcache_fill.sv
// thor_dcache_fill: runs one incrementing Wishbone burst per cache miss,
// writes every returned beat into the data RAM, then validates the tag.
// Ports: clk_i/rst_i; req_i/req_adr_i miss request; busy_o/done_o/err_o
// status; cyc_o..adr_o, ack_i/err_i/dat_i Wishbone master; wce_o/wr_o/
// csel_o/wa_o/wd_o cache RAM write port; tag_wr_o/tag_adr_o tag write.
module thor_dcache_fill #(
  parameter int DBW        = 64,
  parameter int LINE_BEATS = 4,
  parameter int TMO        = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [DBW-1:0]   req_adr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [2:0]       cti_o,
  output logic [1:0]       bte_o,
  output logic [DBW/8-1:0] bsel_o,
  output logic [DBW-1:0]   adr_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [DBW-1:0]   dat_i,
  output logic             wce_o,
  output logic             wr_o,
  output logic [DBW/8-1:0] csel_o,
  output logic [DBW-1:0]   wa_o,
  output logic [DBW-1:0]   wd_o,
  output logic             tag_wr_o,
  output logic [DBW-1:0]   tag_adr_o
);

  localparam int BB = DBW / 8;
  localparam int CW = $clog2(LINE_BEATS);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [DBW-1:0] LMASK = DBW'(LINE_BEATS * BB - 1);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FINISH
  } state_t;

  state_t         state;
  logic [CW-1:0]  beat;
  logic [TW-1:0]  tmo;
  logic [DBW-1:0] base;
  logic           last;
  logic           nx_last;
  logic           tmo_hit;

  assign we_o   = 1'b0;
  assign bte_o  = 2'b00;
  assign bsel_o = '1;

  assign base    = req_adr_i & ~LMASK;
  assign last    = beat == CW'(LINE_BEATS - 1);
  assign nx_last = beat == CW'(LINE_BEATS - 2);
  // tmo reads 0 in the cycle after an ack and err_o is registered, so
  // firing at TMO-2 puts err_o exactly TMO cycles after the last ack.
  assign tmo_hit = tmo == TW'(TMO - 2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      beat      <= '0;
      tmo       <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      cti_o     <= 3'b000;
      adr_o     <= '0;
      wce_o     <= 1'b0;
      wr_o      <= 1'b0;
      csel_o    <= '0;
      wa_o      <= '0;
      wd_o      <= '0;
      tag_wr_o  <= 1'b0;
      tag_adr_o <= '0;
    end else begin
      wce_o    <= 1'b0;
      wr_o     <= 1'b0;
      csel_o   <= '0;
      tag_wr_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      unique case (state)
        IDLE, FINISH: begin
          if (req_i) begin
            state     <= BURST;
            adr_o     <= base;
            tag_adr_o <= base;
            beat      <= '0;
            tmo       <= '0;
            busy_o    <= 1'b1;
            cyc_o     <= 1'b1;
            stb_o     <= 1'b1;
            cti_o     <= CTI_INC;
          end else begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (err_i || (!ack_i && tmo_hit)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            cti_o  <= 3'b000;
            err_o  <= 1'b1;
          end else if (ack_i) begin
            wce_o  <= 1'b1;
            wr_o   <= 1'b1;
            csel_o <= '1;
            wa_o   <= adr_o;
            wd_o   <= dat_i;
            adr_o  <= adr_o + DBW'(BB);
            beat   <= beat + 1'b1;
            tmo    <= '0;
            if (last) begin
              state    <= FINISH;
              busy_o   <= 1'b0;
              cyc_o    <= 1'b0;
              stb_o    <= 1'b0;
              cti_o    <= 3'b000;
              tag_wr_o <= 1'b1;
              done_o   <= 1'b1;
            end else begin
              cti_o <= nx_last ? CTI_END : CTI_INC;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
